// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter_if
// Brief   : Bus bundle for the register-file write-port arbiter: pipeline
//           writeback, long-unit results, RF write port and hazard queries.
// Revision: 1.0
// ============================================================================
interface regfile_wb_arbiter_if;
    logic        pipe_wb_valid;
    logic [4:0]  pipe_wb_addr;
    logic [31:0] pipe_wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;

    modport master (
        output pipe_wb_valid, pipe_wb_addr, pipe_wb_data,
        output lu_valid, lu_addr, lu_data,
        output issue_valid, issue_addr, rs1_addr, rs2_addr,
        input  lu_ready, pipe_stall, rf_we, rf_waddr, rf_wdata,
        input  rs1_busy, rs2_busy
    );

    modport slave (
        input  pipe_wb_valid, pipe_wb_addr, pipe_wb_data,
        input  lu_valid, lu_addr, lu_data,
        input  issue_valid, issue_addr, rs1_addr, rs2_addr,
        output lu_ready, pipe_stall, rf_we, rf_waddr, rf_wdata,
        output rs1_busy, rs2_busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter
// Brief   : Shares the RF write port between pipeline writeback (priority) and
//           a buffered long-latency result stream with a starvation guard.
//           Define RF_ARB_SCOREBOARD_EN to build the pending-destination
//           scoreboard used for RAW hazard queries.
// Revision: 1.0
// ============================================================================
module regfile_wb_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int                 c_PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                 c_CNT_W      = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL       = c_CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]         c_STARVE_MAX = 4'(STARVE_MAX);

    logic [4:0]         r_fifo_addr [FIFO_DEPTH];
    logic [31:0]        r_fifo_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [3:0]         r_starve;
    logic               r_stall;
    logic               r_rf_we;
    logic [4:0]         r_rf_waddr;
    logic [31:0]        r_rf_wdata;

    logic               w_empty;
    logic               w_full;
    logic               w_pipe_req;
    logic               w_pop;
    logic               w_push;
    logic               w_starved;
    logic               w_starve_hit;
    logic [4:0]         w_head_addr;
    logic [31:0]        w_head_data;
    logic               w_head_write;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == c_FULL);
    assign w_pipe_req   = bus.pipe_wb_valid && (bus.pipe_wb_addr != 5'd0);
    assign w_pop        = !w_pipe_req && !w_empty;
    assign w_push       = bus.lu_valid && !w_full;
    assign w_head_addr  = r_fifo_addr[r_rd_ptr];
    assign w_head_data  = r_fifo_data[r_rd_ptr];
    // x0 entries drain through the pop path but never reach the write port
    assign w_head_write = w_pop && (w_head_addr != 5'd0);
    assign w_starved    = !w_empty && !w_pop;
    assign w_starve_hit = w_starved && ((r_starve + 4'd1) == c_STARVE_MAX);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.lu_addr;
            r_fifo_data[r_wr_ptr] <= bus.lu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // The stall lands one cycle after the limit is hit, so the head is granted
    // STARVE_MAX+1 cycles after it became poppable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_stall <= w_starve_hit;
            if (!w_starved || w_starve_hit) begin
                r_starve <= '0;
            end else begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_pipe_req || w_head_write;
            if (w_pipe_req) begin
                r_rf_waddr <= bus.pipe_wb_addr;
                r_rf_wdata <= bus.pipe_wb_data;
            end else if (w_pop) begin
                r_rf_waddr <= w_head_addr;
                r_rf_wdata <= w_head_data;
            end
        end
    end

    assign bus.lu_ready   = !w_full;
    assign bus.pipe_stall = r_stall;
    assign bus.rf_we      = r_rf_we;
    assign bus.rf_waddr   = r_rf_waddr;
    assign bus.rf_wdata   = r_rf_wdata;

`ifdef RF_ARB_SCOREBOARD_EN
    logic [31:1] r_busy;
    logic [31:0] w_busy_vec;

    // Set has priority so a re-issue racing the final writeback stays pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (bus.issue_valid && (bus.issue_addr == 5'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (w_head_write && (w_head_addr == 5'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    assign w_busy_vec   = {r_busy, 1'b0};
    assign bus.rs1_busy = w_busy_vec[bus.rs1_addr];
    assign bus.rs2_busy = w_busy_vec[bus.rs2_addr];
`else
    logic w_unused_sb;
    assign w_unused_sb  = &{1'b0, bus.issue_valid, bus.issue_addr, bus.rs1_addr, bus.rs2_addr};
    assign bus.rs1_busy = 1'b0;
    assign bus.rs2_busy = 1'b0;
`endif

endmodule
`default_nettype wire
